// File: rtl/fastica_pkg.sv
// ---------------------------------------------------------------------------
// fastica_pkg
// Shared definitions for the FastICA datapath: default sample width, channel
// count, the replay controller state encoding, and channel pack/unpack
// macros used wherever a NUM_CH*DATA_W bus carries per-channel samples
// (channel c lives at bus[c*DATA_W +: DATA_W]).
// ---------------------------------------------------------------------------
`ifndef FASTICA_PKG_SV
`define FASTICA_PKG_SV

// Extract channel c (width w) from a packed channel bus.
`define FASTICA_CH_GET(bus, c, w) bus[(c)*(w) +: (w)]
// Place value val into channel c (width w) of a packed channel bus.
`define FASTICA_CH_SET(bus, c, w, val) bus[(c)*(w) +: (w)] = (val)

package fastica_pkg;

  // Sample word width, matching the W-matrix word width of the core.
  localparam int FASTICA_DATA_W = 26;
  // Default number of whitened channels.
  localparam int FASTICA_NUM_CH = 4;

  // Replay controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REPLAY  = 2'd2,
    ST_DONE    = 2'd3
  } fastica_state_e;

  // The block reports busy in every state except IDLE.
  function automatic logic fastica_state_busy(input fastica_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

`endif

// File: rtl/fastica_sample_ram.sv
// ---------------------------------------------------------------------------
// fastica_sample_ram
// Simple dual-port sample store: one write port, one synchronous read port
// with one cycle of read latency. rd_data holds its value on cycles where
// rd_en is low, which the replay prefetch logic relies on. Contents are not
// cleared by reset.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe (rd_data updates on the next edge)
//   rd_addr  in   read address
//   rd_data  out  registered read data
// ---------------------------------------------------------------------------
module fastica_sample_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 104,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fastica_sample_replay.sv
// ---------------------------------------------------------------------------
// fastica_sample_replay
// Captures DEPTH whitened NUM_CH-channel samples into on-chip memory, then
// replays the whole block NUM_PASS times to the FastICA core over a
// valid/ready stream, so every fixed-point iteration sees the same data.
//
// Optional feature macro: FASTICA_OVF_FLAG_EN
//   defined   : z_in_valid during REPLAY/DONE sets the sticky ovf_flag,
//               cleared by reset or by a go_fast accepted in IDLE.
//   undefined : ovf_flag is tied low.
//
// Ports:
//   clk_fast     in   clock, rising edge
//   rst_fast_n   in   synchronous active-low reset
//   go_fast      in   start pulse, honoured only in IDLE
//   z_in         in   packed input sample, channel c at [c*DATA_W +: DATA_W]
//   z_in_valid   in   z_in qualifier, stored only in CAPTURE
//   fast_busy    out  high in CAPTURE/REPLAY/DONE
//   z_out        out  replayed sample, same packing as z_in
//   z_out_valid  out  z_out holds a valid sample
//   z_out_ready  in   core accepts z_out when valid && ready
//   z_out_last   out  z_out is sample DEPTH-1 of the current pass
//   pass_idx     out  current pass number, 0-based
//   done         out  one-cycle pulse after the final pass is accepted
//   ovf_flag     out  sticky capture-overrun flag
//
// Replay pipeline: RAM read register (stage 1) feeding the output register.
// Stage 1 is refilled in the same cycle it hands its sample forward, giving
// one accepted sample per cycle while ready stays high, and both stages
// simply hold while the output is stalled.
// ---------------------------------------------------------------------------
module fastica_sample_replay
  import fastica_pkg::*;
#(
  parameter int DATA_W   = FASTICA_DATA_W,
  parameter int NUM_CH   = FASTICA_NUM_CH,
  parameter int DEPTH    = 256,
  parameter int NUM_PASS = 8,
  localparam int ZW = NUM_CH * DATA_W,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = $clog2(NUM_PASS + 1)
) (
  input  logic          clk_fast,
  input  logic          rst_fast_n,
  input  logic          go_fast,
  input  logic [ZW-1:0] z_in,
  input  logic          z_in_valid,
  output logic          fast_busy,
  output logic [ZW-1:0] z_out,
  output logic          z_out_valid,
  input  logic          z_out_ready,
  output logic          z_out_last,
  output logic [PW-1:0] pass_idx,
  output logic          done,
  output logic          ovf_flag
);

  fastica_state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_pass_q, rd_pass_d;
  logic          rd_done_q, rd_done_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q, s1_last_d;
  logic [ZW-1:0] z_out_q, z_out_d;
  logic          z_out_valid_q, z_out_valid_d;
  logic          z_out_last_q, z_out_last_d;
  logic [PW-1:0] pass_idx_q, pass_idx_d;
  logic          done_q, done_d;
  logic          fast_busy_q, fast_busy_d;

  logic          out_adv_s;
  logic          accept_s;
  logic          move_s;
  logic          issue_s;
  logic          ram_we_s;
  logic [ZW-1:0] ram_rdata_s;

  // Handshake and pipeline-advance qualifiers.
  always_comb begin
    out_adv_s = (!z_out_valid_q) || z_out_ready;
    accept_s  = z_out_valid_q && z_out_ready;
    move_s    = s1_valid_q && out_adv_s;
    issue_s   = (state_q == ST_REPLAY) && (!rd_done_q) && ((!s1_valid_q) || move_s);
    ram_we_s  = (state_q == ST_CAPTURE) && z_in_valid;
  end

  fastica_sample_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ZW)
  ) u_ram (
    .clk     (clk_fast),
    .wr_en   (ram_we_s),
    .wr_addr (wr_ptr_q),
    .wr_data (z_in),
    .rd_en   (issue_s),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata_s)
  );

  // Next-state, pointer, pass counter and output-register logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_pass_d     = rd_pass_q;
    rd_done_d     = rd_done_q;
    s1_valid_d    = s1_valid_q;
    s1_last_d     = s1_last_q;
    z_out_d       = z_out_q;
    z_out_valid_d = z_out_valid_q;
    z_out_last_d  = z_out_last_q;
    pass_idx_d    = pass_idx_q;

    // Read-issue side runs ahead of the accept side; it tracks its own pass
    // count so it stops exactly after the last sample of the last pass.
    if (issue_s) begin
      rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      s1_valid_d = 1'b1;
      s1_last_d  = (rd_ptr_q == AW'(DEPTH - 1));
      if (rd_ptr_q == AW'(DEPTH - 1)) begin
        if (rd_pass_q == PW'(NUM_PASS - 1)) begin
          rd_done_d = 1'b1;
        end else begin
          rd_pass_d = rd_pass_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end else begin
        rd_pass_d = rd_pass_q;
      end
    end else if (move_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Output register loads whenever it is empty or being accepted.
    if (out_adv_s) begin
      z_out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_out_d      = ram_rdata_s;
        z_out_last_d = s1_last_q;
      end else begin
        z_out_last_d = 1'b0;
      end
    end else begin
      z_out_valid_d = z_out_valid_q;
    end

    if (accept_s && z_out_last_q) begin
      pass_idx_d = pass_idx_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      pass_idx_d = pass_idx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (go_fast) begin
          state_d    = ST_CAPTURE;
          wr_ptr_d   = {AW{1'b0}};
          rd_ptr_d   = {AW{1'b0}};
          rd_pass_d  = {PW{1'b0}};
          rd_done_d  = 1'b0;
          s1_valid_d = 1'b0;
          pass_idx_d = {PW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (z_in_valid) begin
          wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            state_d = ST_REPLAY;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_REPLAY: begin
        if (accept_s && z_out_last_q && (pass_idx_q == PW'(NUM_PASS - 1))) begin
          state_d       = ST_DONE;
          z_out_valid_d = 1'b0;
          z_out_last_d  = 1'b0;
        end else begin
          state_d = ST_REPLAY;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        pass_idx_d = {PW{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d      = (state_d == ST_DONE);
    fast_busy_d = fastica_state_busy(state_d);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_fast) begin
    if (!rst_fast_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      rd_pass_q     <= {PW{1'b0}};
      rd_done_q     <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      z_out_q       <= {ZW{1'b0}};
      z_out_valid_q <= 1'b0;
      z_out_last_q  <= 1'b0;
      pass_idx_q    <= {PW{1'b0}};
      done_q        <= 1'b0;
      fast_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_pass_q     <= rd_pass_d;
      rd_done_q     <= rd_done_d;
      s1_valid_q    <= s1_valid_d;
      s1_last_q     <= s1_last_d;
      z_out_q       <= z_out_d;
      z_out_valid_q <= z_out_valid_d;
      z_out_last_q  <= z_out_last_d;
      pass_idx_q    <= pass_idx_d;
      done_q        <= done_d;
      fast_busy_q   <= fast_busy_d;
    end
  end

  assign z_out       = z_out_q;
  assign z_out_valid = z_out_valid_q;
  assign z_out_last  = z_out_last_q;
  assign pass_idx    = pass_idx_q;
  assign done        = done_q;
  assign fast_busy   = fast_busy_q;

`ifdef FASTICA_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Overrun detection: input arriving after capture is dropped but flagged.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == ST_IDLE) && go_fast) begin
      ovf_d = 1'b0;
    end else if (z_in_valid && ((state_q == ST_REPLAY) || (state_q == ST_DONE))) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky overrun flag register.
  always_ff @(posedge clk_fast) begin
    if (!rst_fast_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_flag = ovf_q;
`else
  assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fastica_sample_replay.sv
module tb_fastica_sample_replay;
  import fastica_pkg::*;

  localparam int DATA_W   = 26;
  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 4;
  localparam int NUM_PASS = 2;
  localparam int ZW       = NUM_CH * DATA_W;
  localparam int PW       = $clog2(NUM_PASS + 1);
`ifdef FASTICA_OVF_FLAG_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct packed {
    logic [ZW-1:0] data;
    logic          last;
    logic [PW-1:0] pass;
  } exp_t;

  logic          clk_fast = 1'b0;
  logic          rst_fast_n;
  logic          go_fast;
  logic [ZW-1:0] z_in;
  logic          z_in_valid;
  logic          fast_busy;
  logic [ZW-1:0] z_out;
  logic          z_out_valid;
  logic          z_out_ready;
  logic          z_out_last;
  logic [PW-1:0] pass_idx;
  logic          done;
  logic          ovf_flag;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];

  always #5 clk_fast = ~clk_fast;

  fastica_sample_replay #(
    .DATA_W   (DATA_W),
    .NUM_CH   (NUM_CH),
    .DEPTH    (DEPTH),
    .NUM_PASS (NUM_PASS)
  ) dut (
    .clk_fast    (clk_fast),
    .rst_fast_n  (rst_fast_n),
    .go_fast     (go_fast),
    .z_in        (z_in),
    .z_in_valid  (z_in_valid),
    .fast_busy   (fast_busy),
    .z_out       (z_out),
    .z_out_valid (z_out_valid),
    .z_out_ready (z_out_ready),
    .z_out_last  (z_out_last),
    .pass_idx    (pass_idx),
    .done        (done),
    .ovf_flag    (ovf_flag)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Channel c carries v + c so channel packing errors are visible.
  function automatic logic [ZW-1:0] pack(input int v);
    logic [ZW-1:0] r;
    for (int c = 0; c < NUM_CH; c++) begin
      r[c*DATA_W +: DATA_W] = DATA_W'(v + c);
    end
    return r;
  endfunction

  // Go pulse; the DUT must report busy right after the accepting edge.
  task automatic start();
    go_fast = 1'b1;
    @(posedge clk_fast); #1;
    go_fast = 1'b0;
    chk("busy_after_go", fast_busy, 1'b1);
  endtask

  // Drive a capture pattern; sample k of the valid slots is base*(k+1).
  // Returns one step after the edge that performs the final write.
  task automatic capture(input int base, input logic [15:0] pat, input int plen, input int go_at);
    int k;
    k = 0;
    for (int i = 0; i < plen; i++) begin
      z_in_valid = pat[i];
      if (pat[i]) begin
        z_in = pack(base * (k + 1));
        k++;
      end else begin
        z_in = pack(12345);
      end
      go_fast = (i == go_at);
      @(posedge clk_fast); #1;
    end
    z_in_valid = 1'b0;
    go_fast    = 1'b0;
    z_in       = pack(999);
    for (int p = 0; p < NUM_PASS; p++) begin
      for (int s = 0; s < DEPTH; s++) begin
        exp_q.push_back('{data: pack(base * (s + 1)), last: (s == DEPTH - 1), pass: PW'(p)});
      end
    end
  endtask

  // Run the replay until done (bounded), driving ready per mode.
  task automatic wait_done(input logic toggle, input int go_at, output logic got);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      z_out_ready = toggle ? ((i % 2) == 0) : 1'b1;
      go_fast     = (i == go_at);
      @(negedge clk_fast);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk_fast); #1;
    end
    go_fast = 1'b0;
    chk("done_seen", got, 1'b1);
  endtask

  // Output monitor: scoreboard pop on accept, hold check while stalled.
  initial begin
    logic          hold_pend;
    logic [ZW-1:0] held_data;
    logic          held_last;
    exp_t          e;
    hold_pend = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk_fast);
      if (!mon_en) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", z_out_valid, 1'b1);
          chk("hold_data", z_out, held_data);
          chk("hold_last", z_out_last, held_last);
        end
        if (z_out_valid && z_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_output", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("z_out", z_out, e.data);
            chk("z_out_last", z_out_last, e.last);
            chk("pass_idx", pass_idx, e.pass);
          end
          hold_pend = 1'b0;
        end else if (z_out_valid) begin
          hold_pend = 1'b1;
          held_data = z_out;
          held_last = z_out_last;
        end else begin
          hold_pend = 1'b0;
        end
        if (done) done_cnt++;
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic got;
    int   dc;
    rst_fast_n  = 1'b0;
    go_fast     = 1'b0;
    z_in        = '0;
    z_in_valid  = 1'b0;
    z_out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk_fast);
    @(negedge clk_fast);
    chk("rst_busy", fast_busy, 1'b0);
    chk("rst_z_out", z_out, '0);
    chk("rst_valid", z_out_valid, 1'b0);
    chk("rst_last", z_out_last, 1'b0);
    chk("rst_pass_idx", pass_idx, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf_flag, 1'b0);
    @(posedge clk_fast); #1;
    rst_fast_n = 1'b1;
    mon_en     = 1'b1;

    // Test 1: back-to-back capture, ready held high, latency and no gaps.
    start();
    capture(8200, 16'h000F, 4, -1);
    @(negedge clk_fast);
    chk("lat_cycle1_valid", z_out_valid, 1'b0);
    @(negedge clk_fast);
    chk("lat_cycle2_valid", z_out_valid, 1'b0);
    @(negedge clk_fast);
    chk("lat_first_valid", z_out_valid, 1'b1);
    for (int i = 1; i < NUM_PASS * DEPTH; i++) begin
      @(negedge clk_fast);
      chk("nogap_valid", z_out_valid, 1'b1);
    end
    @(negedge clk_fast);
    chk("t1_done", done, 1'b1);
    chk("t1_busy_in_done", fast_busy, 1'b1);
    chk("t1_valid_dropped", z_out_valid, 1'b0);
    @(negedge clk_fast);
    chk("t1_done_one_cycle", done, 1'b0);
    chk("t1_idle_busy", fast_busy, 1'b0);
    chk("t1_pass_idx_idle", pass_idx, '0);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_ovf", ovf_flag, 1'b0);
    @(posedge clk_fast); #1;

    // Test 2: ready toggling 1,0,1,0 during replay.
    start();
    capture(8200, 16'h000F, 4, -1);
    wait_done(1'b1, -1, got);
    z_out_ready = 1'b1;
    @(posedge clk_fast); #1;
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_done_count", done_cnt, 2);

    // Tests 3 and 5: capture with valid gaps, go pulses in CAPTURE/REPLAY,
    // and go coincident with done.
    start();
    capture(1000, 16'b1001011, 7, 2);
    dc = done_cnt;
    wait_done(1'b0, 3, got);
    go_fast = 1'b1;
    @(posedge clk_fast); #1;
    go_fast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_fast);
      chk("t5_stay_idle", fast_busy, 1'b0);
    end
    chk("t3_queue_empty", exp_q.size(), 0);
    chk("t5_one_done", done_cnt, dc + 1);
    @(posedge clk_fast); #1;

    // Test 4: reset during pass 1, then a clean restart.
    start();
    capture(8200, 16'h000F, 4, -1);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_fast);
      if (z_out_valid && (pass_idx == PW'(1))) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4_reached_pass1", got, 1'b1);
    @(posedge clk_fast); #1;
    mon_en     = 1'b0;
    rst_fast_n = 1'b0;
    exp_q.delete();
    @(posedge clk_fast);
    @(negedge clk_fast);
    chk("t4_rst_busy", fast_busy, 1'b0);
    chk("t4_rst_valid", z_out_valid, 1'b0);
    chk("t4_rst_z_out", z_out, '0);
    chk("t4_rst_last", z_out_last, 1'b0);
    chk("t4_rst_pass_idx", pass_idx, '0);
    chk("t4_rst_done", done, 1'b0);
    @(posedge clk_fast); #1;
    rst_fast_n = 1'b1;
    mon_en     = 1'b1;
    dc = done_cnt;
    start();
    capture(3300, 16'h000F, 4, -1);
    wait_done(1'b0, -1, got);
    @(posedge clk_fast); #1;
    chk("t4_queue_empty", exp_q.size(), 0);
    chk("t4_done_count", done_cnt, dc + 1);

    // Test 6: negative samples and input arriving during replay.
    start();
    capture(-8200, 16'h000F, 4, -1);
    z_in_valid = 1'b1;
    z_in       = pack(777);
    wait_done(1'b0, -1, got);
    chk("t6_ovf_after_replay", ovf_flag, EXP_OVF);
    @(posedge clk_fast); #1;
    z_in_valid = 1'b0;
    @(negedge clk_fast);
    chk("t6_ovf_sticky_idle", ovf_flag, EXP_OVF);
    chk("t6_queue_empty", exp_q.size(), 0);
    @(posedge clk_fast); #1;
    start();
    chk("t6_ovf_cleared_by_go", ovf_flag, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
